// File: rtl/fifo_rd_pkg.sv
// ============================================================================
// Module : fifo_rd_pkg
// Brief  : Shared types and constants for the FIFO stream reader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_pkg;

  localparam int FIFO_RD_BUF_DEPTH = 2;

  typedef logic [1:0]  occ_t;
  typedef logic [15:0] wcount_t;

endpackage

`default_nettype wire

// File: rtl/fifo_if.sv
// ============================================================================
// Module : fifo_if
// Brief  : Read side of the team synchronous FIFO (pop, empty, data_out).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_if #(
  parameter int SIZE = 8
);

  logic            rd;
  logic            empty;
  logic [SIZE-1:0] data_out;

  // master pops the FIFO; slave is the FIFO itself
  modport master (output rd, input empty, input data_out);
  modport slave  (input rd, output empty, output data_out);

endinterface

`default_nettype wire

// File: rtl/fifo_rd_skid_buf.sv
// ============================================================================
// Module : fifo_rd_skid_buf
// Brief  : Two-entry circular output buffer with occupancy count.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            push,
  input  wire logic [SIZE-1:0] push_data,
  input  wire logic            pop,
  output occ_t                 occ,
  output logic      [SIZE-1:0] head_data
);

  logic [SIZE-1:0] r_buf [0:FIFO_RD_BUF_DEPTH-1];
  logic            r_head;
  logic            r_tail;
  occ_t            r_occ;

  // Single-bit pointers wrap 1 -> 0 naturally for a depth of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (push) begin
        r_buf[r_tail] <= push_data;
        r_tail        <= ~r_tail;
      end
      if (pop) begin
        r_head <= ~r_head;
      end
      r_occ <= r_occ + occ_t'(push) - occ_t'(pop);
    end
  end

  assign occ       = r_occ;
  assign head_data = r_buf[r_head];

endmodule

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ============================================================================
// Module : fifo_stream_reader
// Brief  : Pops the FIFO read port and re-presents words on a valid/ready
//          stream at full throughput. FIFO_RD_CNT_EN adds a delivered-word
//          counter on port word_count.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int BUF_DEPTH = 2
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            en,
  fifo_if.master               fifo,
  output logic      [SIZE-1:0] m_data,
  output logic                 m_valid,
  input  wire logic            m_ready
`ifdef FIFO_RD_CNT_EN
  ,
  output wcount_t              word_count
`endif
);

  generate
    if (BUF_DEPTH != FIFO_RD_BUF_DEPTH) begin : g_bad_depth
      $error("fifo_stream_reader: BUF_DEPTH must be 2");
    end
  endgenerate

  logic       r_inflight;
  occ_t       w_occ;
  logic       w_pop_out;
  logic [2:0] w_credit;
  logic       w_rd;

  assign w_pop_out = m_valid && m_ready;

  // Slots committed after this edge; pop_out implies occ >= 1, so no underflow
  assign w_credit = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop_out};
  assign w_rd     = !rst && en && !fifo.empty && (w_credit < 3'd2);
  assign fifo.rd  = w_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
    end
  end

  fifo_rd_skid_buf #(
    .SIZE (SIZE)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (r_inflight),
    .push_data (fifo.data_out),
    .pop       (w_pop_out),
    .occ       (w_occ),
    .head_data (m_data)
  );

  assign m_valid = (w_occ != 2'd0);

`ifdef FIFO_RD_CNT_EN
  wcount_t r_word_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_count <= '0;
    end else if (w_pop_out) begin
      r_word_count <= r_word_count + 16'd1;
    end
  end

  assign word_count = r_word_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
// Module : tb_fifo_stream_reader
// Brief  : Self-checking bench with a queue-based FIFO and stream scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_stream_reader;

  logic       clk;
  logic       rst;
  logic       en;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_valid;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] word_count;
`endif

  fifo_if #(.SIZE(8)) fifo_b ();

  fifo_stream_reader #(
    .SIZE      (8),
    .BUF_DEPTH (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .fifo    (fifo_b),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready)
`ifdef FIFO_RD_CNT_EN
    ,
    .word_count (word_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural FIFO: one-cycle read latency, empty reflects stored count
  logic [7:0] fq[$];
  logic       prod_wr;
  logic [7:0] prod_data;
  int         popped;
  int         cyc = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      popped = 0;
      fifo_b.data_out <= 8'h00;
      fifo_b.empty    <= 1'b1;
    end else begin
      if (fifo_b.rd && fq.size() != 0) begin
        fifo_b.data_out <= fq.pop_front();
        popped++;
      end
      if (prod_wr) fq.push_back(prod_data);
      fifo_b.empty <= (fq.size() == 0);
    end
  end

  // Scoreboard: every written word appears once, in write order
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;
  int         delivered;
  int         efall;
  int         first_del;
  int         last_del;
  logic [7:0] first_data;
  logic       prev_empty = 1'b1;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      delivered  = 0;
      prev_stall = 1'b0;
      prev_empty = 1'b1;
    end else begin
      if (fifo_b.rd) check("rd_gate", {31'b0, en && !fifo_b.empty}, 32'd1);
      check("outstanding_le_2", {31'b0, (popped - delivered) <= 2}, 32'd1);
      if (prev_stall) begin
        check("hold_valid", {31'b0, m_valid}, 32'd1);
        check("hold_data", {24'b0, m_data}, {24'b0, prev_data});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", {24'b0, m_data}, 32'hFFFF_FFFF);
        end else begin
          exp_word = exp_q.pop_front();
          check("order", {24'b0, m_data}, {24'b0, exp_word});
        end
        if (first_del < 0) begin
          first_del  = cyc;
          first_data = m_data;
        end
        last_del = cyc;
        delivered++;
      end
      if (prev_empty && !fifo_b.empty && efall < 0) efall = cyc;
      prev_empty = fifo_b.empty;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_marks();
    efall     = -1;
    first_del = -1;
    last_del  = -1;
  endtask

  task automatic write_word(input logic [7:0] d);
    prod_wr   = 1'b1;
    prod_data = d;
    exp_q.push_back(d);
    tick();
    prod_wr   = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", {31'b0, exp_q.size() == 0 && !m_valid}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int d0;
  int p0;
  int sent;
  int guard;

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    m_ready = 1'b0;
    prod_wr = 1'b0;
    prod_data = 8'h00;
    clear_marks();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {31'b0, m_valid}, 32'd0);
    check("reset_rd", {31'b0, fifo_b.rd}, 32'd0);
    check("reset_data", {24'b0, m_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Full-rate burst: latency and back-to-back delivery
    en = 1'b1; m_ready = 1'b1;
    clear_marks();
    d0 = delivered;
    write_word(8'h11); write_word(8'h22); write_word(8'h33); write_word(8'h44);
    wait_drain(20);
    check("burst_count", delivered - d0, 32'd4);
    check("burst_latency", first_del - efall, 32'd2);
    check("burst_back_to_back", last_del - first_del, 32'd3);

    // Backpressure: only two pops until ready returns
    m_ready = 1'b0;
    d0 = delivered; p0 = popped;
    write_word(8'h11); write_word(8'h22); write_word(8'h33); write_word(8'h44);
    repeat (5) tick();
    check("bp_pops", popped - p0, 32'd2);
    check("bp_fifo_count", fq.size(), 32'd2);
    check("bp_occ", {30'b0, dut.u_buf.occ}, 32'd2);
    check("bp_valid", {31'b0, m_valid}, 32'd1);
    check("bp_data", {24'b0, m_data}, 32'h11);
    check("bp_rd_low", {31'b0, fifo_b.rd}, 32'd0);
    m_ready = 1'b1;
    wait_drain(20);
    check("bp_drained", delivered - d0, 32'd4);

    // Ready toggling against a continuously filled FIFO
    d0 = delivered;
    for (int i = 0; i < 8; i++) begin
      m_ready = (i % 2 == 0);
      write_word(8'hA0 + 8'(i));
    end
    guard = 0;
    while ((exp_q.size() != 0 || m_valid) && guard < 40) begin
      m_ready = ~m_ready;
      tick();
      guard++;
    end
    check("toggle_count", delivered - d0, 32'd8);
    m_ready = 1'b1;

    // Enable dropped right after the first pop
    en = 1'b0;
    write_word(8'h31); write_word(8'h32); write_word(8'h33);
    d0 = delivered; p0 = popped;
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("en_low_rd", {31'b0, fifo_b.rd}, 32'd0);
    end
    check("en_low_pops", popped - p0, 32'd1);
    check("en_low_delivered", delivered - d0, 32'd1);
    en = 1'b1;
    wait_drain(20);
    check("en_resume", delivered - d0, 32'd3);

`ifdef FIFO_RD_CNT_EN
    check("count_before_reset", {16'b0, word_count}, {16'b0, 16'(delivered)});
`endif

    // Asynchronous reset mid-burst with a word in flight and one buffered
    write_word(8'h61); write_word(8'h62); write_word(8'h63);
    check("pre_rst_occ", {30'b0, dut.u_buf.occ}, 32'd1);
    check("pre_rst_inflight", {31'b0, dut.r_inflight}, 32'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_valid", {31'b0, m_valid}, 32'd0);
    check("mid_rst_rd", {31'b0, fifo_b.rd}, 32'd0);
    check("mid_rst_data", {24'b0, m_data}, 32'd0);
`ifdef FIFO_RD_CNT_EN
    check("mid_rst_count", {16'b0, word_count}, 32'd0);
`endif
    tick();
    rst = 1'b0;
    clear_marks();
    write_word(8'h5A);
    wait_drain(20);
    check("post_rst_first", {24'b0, first_data}, 32'h5A);
    check("post_rst_count", delivered, 32'd1);

    // Random producer, enable and ready against the queue model
    d0 = delivered;
    sent = 0;
    guard = 0;
    while (sent < 200 && guard < 5000) begin
      m_ready   = ($urandom_range(0, 9) < 7);
      en        = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 3) != 0 && fq.size() < 12) begin
        write_word(8'($urandom()));
        sent++;
      end else begin
        tick();
      end
      guard++;
    end
    en = 1'b1; m_ready = 1'b1;
    wait_drain(100);
    check("random_count", delivered - d0, 32'd200);

`ifdef FIFO_RD_CNT_EN
    // Counter wrap: 70000 deliveries from a fresh reset
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 70000; i++) write_word(8'(i));
    wait_drain(50);
    check("count_wrap", {16'b0, word_count}, 32'd4464);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drain engine for the team's synchronous FIFO: issues `rd` pops against the FIFO's read port and re-presents the popped words on a valid/ready stream. It hides the FIFO's one-cycle read latency and `empty` gating behind a 2-entry output buffer, so a downstream consumer that applies backpressure still gets full throughput. It sits directly on the read side of a `fifo_if` instance. The write side stays with the producer.

## Interface
Parameters:
- `SIZE`, 8, data width. Must equal the FIFO's `size`.
- `BUF_DEPTH`, 2, output buffer entries. Fixed at 2; elaborate-time `$error` if any other value is given.

Ports:
- `clk`  in  1  single clock, shared with the FIFO.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  drain enable. When low, no new pops are issued. Buffered and in-flight words still drain.
- `fifo_rd`  out  1  pop request to the FIFO. Combinational.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  SIZE  FIFO `data_out`. Valid the cycle after a pop edge.
- `m_data`  out  SIZE  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready from the consumer.
- `word_count`  out  16  words delivered. Present only with `FIFO_RD_CNT_EN`.

## Operation
- State:
  - `occ`: buffer occupancy, 0..2.
  - `inflight`: 1 bit, set when a pop was accepted last edge and its data is still pending capture.
  - `buf[0:1]`, with circular head/tail pointers.
- `pop_out = m_valid && m_ready`.
- `fifo_rd = en && !fifo_empty && (occ + inflight - pop_out) < 2`. Compute this in 3 bits, unsigned, with no underflow because `pop_out` implies `occ >= 1`. Force it to 0 while `rst` is high.
- A pop is accepted at an edge iff `fifo_rd` is high at that edge. This is guaranteed because `fifo_rd` already includes `!fifo_empty`.
- `inflight <= fifo_rd` at each edge.
- At an edge where `inflight == 1`:
  - `buf[tail] <= fifo_data`.
  - `tail` advances, wrapping 1→0.
- At an edge where `pop_out` is high, `head` advances, wrapping 1→0.
- `occ <= occ + inflight - pop_out`. Capture and pop on the same edge leave `occ` unchanged.
- `m_valid = (occ != 0)`. `m_data = buf[head]`. Both are registered-state outputs; there is no combinational path from `fifo_data`.
- The credit rule guarantees no overflow: `occ + inflight` never exceeds 2.
- Words leave in strict FIFO order. No word is dropped or duplicated.
- Reset (asynchronous assert, any time, including mid-transfer):
  - `occ`, `inflight`, `head` and `tail` go to 0, so `m_valid` = 0 and `fifo_rd` = 0.
  - `m_data` = 0 because `buf` is cleared.
  - `word_count` = 0.
  - A word popped before reset is discarded. The FIFO's own reset is expected to coincide.
- Deassertion of `rst` is synchronized externally. The first pop can occur at the first edge after deassertion.

## Timing
- Latency: FIFO goes non-empty before edge N with `occ` = 0 → `fifo_rd` high at N → capture at N+1 → `m_valid` high after N+1. That is 2 cycles from the FIFO holding data to stream valid.
- Throughput: one word per cycle while `m_ready` is held high and the FIFO stays non-empty. Steady state is `occ` = 1, `inflight` = 1.
- Backpressure:
  - `m_ready` low with `occ` = 2, or `occ` = 1 with `inflight` = 1 → `fifo_rd` low that same cycle.
  - Recovery is immediate: `m_ready` rising re-enables `fifo_rd` combinationally in the same cycle.
- `m_data` and `m_valid` are held stable while `m_valid && !m_ready`.
- `en` falling: no pop at the next edge. An already-accepted in-flight word is still captured and delivered.
- FIFO empty while `inflight` = 1: the capture completes normally and no further pop is issued.

## Configuration
- `FIFO_RD_CNT_EN` defined:
  - Adds the `word_count` port and a 16-bit counter that increments on each `pop_out`.
  - The counter wraps from 65535 to 0 and is cleared by `rst`.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `fifo_rd_pkg`:
  - `FIFO_RD_BUF_DEPTH = 2`.
  - `typedef logic [1:0] occ_t`.
  - `typedef logic [15:0] wcount_t`.
- One sub-module, `fifo_rd_skid_buf`. It holds the 2-entry buffer, the pointers and `occ`, and exposes `push`/`push_data`/`pop`/`occ`/`head_data`.
- The top level holds the credit logic, `inflight` and the optional counter.

## Test plan
- Reset, then the producer writes 0x11, 0x22, 0x33, 0x44 with `m_ready`=1 and `en`=1 → stream delivers 0x11..0x44 on 4 consecutive cycles; first `m_valid` 2 cycles after `fifo_empty` falls.
- Same 4 words with `m_ready`=0 → exactly 2 pops issued, `occ`=2, FIFO count=2, `m_data`=0x11 held stable. Raising `m_ready` then drains all 4 in order.
- `m_ready` toggling 1,0,1,0 against a continuously filled FIFO of 8 words → order preserved, no duplicates, at most one pop per cycle.
- `en` dropped one cycle after the first pop → exactly 1 word delivered; `fifo_rd` stays 0 until `en` returns.
- `rst` asserted mid-burst between clock edges, with `inflight`=1 and `occ`=1 → `m_valid`=0 and `fifo_rd`=0 immediately; after release, the next written word 0x5A is the first delivered.
- With `FIFO_RD_CNT_EN` defined: 70000 words delivered → `word_count` = 4464.
